seven_seg_scan: RTL and testbench
=================================

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 50000: clock cycles each digit is held, legal range >=2.
REQ-003 Port clk, input, 1: single clock; all state on the rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port bcd, input, 4*NUM_DIGITS: hex nibbles; digit i is bcd[4i+3:4i], digit 0 rightmost.
REQ-006 Port dp, input, NUM_DIGITS: decimal-point request per digit, active-high.
REQ-007 Port load, input, 1: one-cycle strobe that captures bcd and dp into the shadow register.
REQ-008 Port lzb, input, 1: leading-zero blanking request; effective only with SEVSEG_LZB_EN.
REQ-009 Port seg, output, 7: segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 Port dec, output, 1: decimal point, active-low, registered.
REQ-011 Port an, output, NUM_DIGITS: digit enables, active-low, one-hot-low or all-high, registered.
REQ-012 Port digit_idx, output, clog2(NUM_DIGITS) with minimum 1: index of the digit currently driven.

Function
REQ-013 Shadow register SHALL capture bcd and dp on the cycle load=1; display content changes only via load.
REQ-014 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; at REFRESH_DIV-1, digit_idx SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0.
REQ-015 seg, dec and an SHALL reflect digit_idx with exactly 1 cycle latency (registered outputs).
REQ-016 Ghost guard: on the cycle an advancing digit_idx is first presented, an SHALL be all-high for that one cycle; the new digit is enabled on the following cycle.
REQ-017 Decode (active-low) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-018 dec SHALL be the inverse of the shadow dp bit of the driven digit.
REQ-019 When load and a digit advance coincide, the advanced digit SHALL use the newly loaded value.
REQ-020 NUM_DIGITS=1: digit_idx stays 0, an[0] is low except on ghost-guard cycles.

Reset
REQ-021 While rst=1: counter=0, digit_idx=0, shadow bcd=0, shadow dp=0, seg=1111111, dec=1, an all-high.
REQ-022 The first digit enable SHALL occur on the second cycle after rst deasserts, showing digit 0.
REQ-023 rst asserted mid-scan SHALL override load and advance in the same cycle.

Configuration
REQ-024 Macro SEVSEG_LZB_EN: when defined and lzb=1, each digit i>0 whose nibble and all higher nibbles are 0 SHALL drive seg=1111111; dec still follows dp; digit 0 is never blanked.
REQ-025 Without SEVSEG_LZB_EN, lzb SHALL be ignored and every digit decoded per REQ-017.

Structure
REQ-026 Package seven_seg_pkg SHALL hold the 16-entry segment constant table, the SEG_OFF constant (1111111), and the digit-index width function.
REQ-027 Sub-module seg_hex_decode (4-bit nibble in, 7-bit active-low segments out, combinational) SHALL implement REQ-017; seven_seg_scan instantiates it once.

Verification
REQ-028 NUM_DIGITS=4, REFRESH_DIV=4, load bcd=16'h1234, dp=4'b0100 -> scan order an=1110/1101/1011/0111 with seg=0011001,0110000,0100100,1111001; dec=0 only while an=1011.
REQ-029 Ghost guard: each digit change -> exactly one cycle with an=1111 before the next enable; digit held 3 cycles of every 4.
REQ-030 With SEVSEG_LZB_EN, lzb=1, bcd=16'h0050 -> digits 3 and 2 seg=1111111, digit 1 seg=0010010, digit 0 seg=1000000; bcd=16'h0000 -> only digit 0 lit showing 0.
REQ-031 rst pulsed mid-scan at digit 2 -> next cycle digit_idx=0, an=1111, seg=1111111, shadow cleared so digit 0 then shows 0.
REQ-032 load coincident with digit advance, bcd=16'hFEDC -> advanced digit shows the new nibble immediately; exhaustive sweep 0..F matches REQ-017.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: the hex glyph
// table (active-low {g,f,e,d,c,b,a}), the all-segments-off pattern and the
// helper that sizes the digit index.
package seven_seg_pkg;

  // Active-low segment vector, bit order {g,f,e,d,c,b,a}.
  typedef logic [6:0] seg_t;

  // All segments dark.
  localparam seg_t SEG_OFF = 7'b1111111;

  // Glyphs for nibble values 0..F, indexed by the nibble itself.
  localparam seg_t SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Width of the digit index: clog2 of the digit count, never below one bit
  // so a single-digit build still has a legal port.
  function automatic int idx_width(input int num_digits);
    return (num_digits <= 1) ? 1 : $clog2(num_digits);
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-seven-segment decoder (active-low outputs).
// A pure table lookup so the glyph set lives in exactly one place.
module seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // Look the nibble up in the shared glyph table.
  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment display driver.
//
// A shadow register holds the displayed nibbles and decimal points and only
// changes on a load strobe. A refresh counter holds each digit for
// REFRESH_DIV cycles; on every digit change the anodes are blanked for one
// cycle (ghost guard) so the previous digit's segments never flash on the
// new digit. seg/dec/an are registered and follow digit_idx by one cycle.
//
// Optional feature, macro SEVSEG_LZB_EN: leading-zero blanking under lzb.
// Without the macro, lzb is ignored and every digit is decoded.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter  int NUM_DIGITS  = 4,
  parameter  int REFRESH_DIV = 50000,
  localparam int IDX_W       = idx_width(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    lzb,
  output logic [6:0]              seg,
  output logic                    dec,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int               CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Scan state
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;

  // Shadow copy of the display content
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [NUM_DIGITS-1:0]   r_dp;

  // Registered pin drivers
  seg_t                    r_seg;
  logic                    r_dec;
  logic [NUM_DIGITS-1:0]   r_an;

  // Combinational helpers
  logic                    w_adv;
  logic [3:0]              w_nib;
  logic                    w_dp_sel;
  logic [NUM_DIGITS-1:0]   w_an_sel;
  seg_t                    w_hex_seg;
  logic                    w_blank;

  // The current digit's hold time expires on this cycle.
  assign w_adv = (r_cnt == CNT_LAST);

  // Refresh counter and digit index: count the hold time, then step to the
  // next digit and wrap after the last one.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of order.
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_adv) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Shadow register: display content changes only through the load strobe.
  always_ff @(posedge clk) begin
    // NOTE: the shadow is a handful of flops rather than a RAM, so it is
    // cleared on reset and the first frame after reset shows a defined 0.
    if (rst) begin
      r_bcd <= '0;
      r_dp  <= '0;
    end else if (load) begin
      r_bcd <= bcd;
      r_dp  <= dp;
    end
  end

  // Select the nibble, decimal point and anode pattern of the current digit.
  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise the
    // paths where no index matches would infer latches.
    w_nib    = 4'h0;
    w_dp_sel = 1'b0;
    w_an_sel = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_bcd[4*i +: 4];
        w_dp_sel    = r_dp[i];
        w_an_sel[i] = 1'b0;
      end
    end
  end

  // Single shared decoder for whichever digit is currently selected.
  seg_hex_decode u_decode (
    .i_nibble (w_nib),
    .o_seg    (w_hex_seg)
  );

`ifdef SEVSEG_LZB_EN
  logic [NUM_DIGITS-1:0] w_blank_mask;

  // A digit above position 0 is a leading zero when it and every digit to
  // its left hold 0; walk from the most significant digit downwards.
  always_comb begin
    logic w_zero_above;
    w_zero_above = 1'b1;
    w_blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_above    = w_zero_above & (r_bcd[4*i +: 4] == 4'h0);
      w_blank_mask[i] = w_zero_above & (i != 0);
    end
  end

  // Blank the selected digit only when blanking is requested.
  always_comb begin
    w_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_blank = lzb & w_blank_mask[i];
      end
    end
  end
`else
  // Blanking is compiled out; lzb is accepted on the port but has no effect.
  logic w_unused_lzb;
  assign w_unused_lzb = lzb;
  assign w_blank      = 1'b0;
`endif

  // Output registers: one cycle behind digit_idx, anodes dark for the single
  // cycle in which a new index is first presented (ghost guard).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= SEG_OFF;
      r_dec <= 1'b1;
      r_an  <= '1;
    end else begin
      r_seg <= w_blank ? SEG_OFF : w_hex_seg;
      r_dec <= ~w_dp_sel;
      r_an  <= w_adv ? '1 : w_an_sel;
    end
  end

  assign seg       = r_seg;
  assign dec       = r_dec;
  assign an        = r_an;
  assign digit_idx = r_idx;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with NUM_DIGITS=4, REFRESH_DIV=4.
// Table vectors load display content and push the expected glyph of every
// digit into a queue; the scan collector pops one entry per digit as the
// DUT enables it. Hand-written sequences cover reset release, mid-scan
// reset and a load that coincides with a digit advance.
// Expectations for lzb follow SEVSEG_LZB_EN when the bench is built with it.
module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd;
  logic [3:0]  dp;
  logic        load;
  logic        lzb;
  logic [6:0]  seg;
  logic        dec;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  seven_seg_scan #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd       (bcd),
    .dp        (dp),
    .load      (load),
    .lzb       (lzb),
    .seg       (seg),
    .dec       (dec),
    .an        (an),
    .digit_idx (digit_idx)
  );

  always #5 clk = ~clk;

  // Glyphs written out independently of the design package.
  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                         G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011,
                         GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110,
                         GF = 7'b0001110, GOFF = 7'b1111111;

  typedef struct {
    logic [15:0]     bcd;
    logic [3:0]      dp;
    logic            lzb;
    logic [3:0][6:0] seg_exp;  // index k = digit k
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dec;
    logic [1:0] idx;
  } exp_t;

  vec_t vecs [6];
  exp_t sb [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the first enable cycle of digit 0 following a guard.
  task automatic wait_digit0_start(output bit ok);
    logic [3:0] prev;
    ok   = 1'b0;
    prev = an;
    for (int i = 0; i < 40; i++) begin
      step();
      if (prev == 4'hF && an == 4'hE) begin
        ok = 1'b1;
        break;
      end
      prev = an;
    end
  endtask

  // Follow one full scan from digit 0, comparing each digit against the
  // queued expectation, its 3-cycle hold and the single guard cycle after it.
  task automatic collect_scan(input string tag);
    bit   ok;
    exp_t e;
    wait_digit0_start(ok);
    check({tag, " digit0 start"}, 32'(ok), 32'd1);
    if (!ok) begin
      sb.delete();
      return;
    end
    for (int k = 0; k < ND; k++) begin
      if (sb.size() == 0) begin
        check({tag, " queue empty"}, 32'd0, 32'd1);
        return;
      end
      e = sb.pop_front();
      check($sformatf("%s d%0d an", tag, k), 32'(an), 32'(e.an));
      check($sformatf("%s d%0d seg", tag, k), 32'(seg), 32'(e.seg));
      check($sformatf("%s d%0d dec", tag, k), 32'(dec), 32'(e.dec));
      check($sformatf("%s d%0d idx", tag, k), 32'(digit_idx), 32'(e.idx));
      step();
      check($sformatf("%s d%0d hold2", tag, k), 32'(an), 32'(e.an));
      step();
      check($sformatf("%s d%0d hold3", tag, k), 32'(an), 32'(e.an));
      step();
      check($sformatf("%s d%0d guard", tag, k), 32'(an), 32'hF);
      if (k < ND - 1) step();
    end
  endtask

  // Load a vector and queue its expected display, digit 0 first.
  task automatic apply_vector(input vec_t v);
    exp_t e;
    bcd  = v.bcd;
    dp   = v.dp;
    lzb  = v.lzb;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < ND; k++) begin
      e.an  = ~(4'b0001 << k);
      e.seg = v.seg_exp[k];
      e.dec = ~v.dp[k];
      e.idx = 2'(k);
      sb.push_back(e);
    end
  endtask

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int run;
    bit found;

    // Expected glyphs, digit 3 first in each concatenation.
    vecs[0] = '{bcd: 16'h1234, dp: 4'b0100, lzb: 1'b0, seg_exp: {G1, G2, G3, G4}};
    vecs[1] = '{bcd: 16'h5678, dp: 4'b0001, lzb: 1'b0, seg_exp: {G5, G6, G7, G8}};
    vecs[2] = '{bcd: 16'h9ABC, dp: 4'b1000, lzb: 1'b0, seg_exp: {G9, GA, GB, GC}};
    vecs[3] = '{bcd: 16'hDEF0, dp: 4'b0000, lzb: 1'b0, seg_exp: {GD, GE, GF, G0}};
`ifdef SEVSEG_LZB_EN
    vecs[4] = '{bcd: 16'h0050, dp: 4'b0000, lzb: 1'b1, seg_exp: {GOFF, GOFF, G5, G0}};
    vecs[5] = '{bcd: 16'h0000, dp: 4'b1010, lzb: 1'b1, seg_exp: {GOFF, GOFF, GOFF, G0}};
`else
    vecs[4] = '{bcd: 16'h0050, dp: 4'b0000, lzb: 1'b1, seg_exp: {G0, G0, G5, G0}};
    vecs[5] = '{bcd: 16'h0000, dp: 4'b1010, lzb: 1'b1, seg_exp: {G0, G0, G0, G0}};
`endif

    // Reset, with a load attempt inside it that must be ignored.
    rst = 1'b1; load = 1'b0; lzb = 1'b0; bcd = '0; dp = '0;
    step();
    bcd = 16'hFFFF; dp = 4'hF; load = 1'b1;
    step();
    load = 1'b0;
    step();
    check("reset an",  32'(an), 32'hF);
    check("reset seg", 32'(seg), 32'(GOFF));
    check("reset dec", 32'(dec), 32'd1);
    check("reset idx", 32'(digit_idx), 32'd0);

    // Release: still dark for the first cycle, digit 0 showing 0 on the second.
    rst = 1'b0;
    #1;
    check("release cycle1 an", 32'(an), 32'hF);
    step();
    check("release cycle2 an",  32'(an), 32'hE);
    check("release cycle2 seg", 32'(seg), 32'(G0));
    check("release cycle2 dec", 32'(dec), 32'd1);
    check("release cycle2 idx", 32'(digit_idx), 32'd0);

    // Table-driven display content.
    for (int v = 0; v < 6; v++) begin
      apply_vector(vecs[v]);
      collect_scan($sformatf("vec%0d", v));
    end
    lzb = 1'b0;

    // Mid-scan reset at digit 2, with a competing load that must lose.
    apply_vector(vecs[0]);
    sb.delete();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (digit_idx == 2'd2 && an == 4'b1011) begin
        found = 1'b1;
        break;
      end
    end
    check("midrst reach digit2", 32'(found), 32'd1);
    rst = 1'b1; bcd = 16'hAAAA; dp = 4'hF; load = 1'b1;
    step();
    check("midrst idx", 32'(digit_idx), 32'd0);
    check("midrst an",  32'(an), 32'hF);
    check("midrst seg", 32'(seg), 32'(GOFF));
    check("midrst dec", 32'(dec), 32'd1);
    rst = 1'b0; load = 1'b0;
    step();
    check("postrst an",  32'(an), 32'hE);
    check("postrst seg", 32'(seg), 32'(G0));
    check("postrst dec", 32'(dec), 32'd1);

    // Load coinciding with the advance from digit 1 to digit 2.
    bcd = 16'h1234; dp = 4'b0000; load = 1'b1;
    step();
    load = 1'b0;
    run = 0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      run = (an == 4'b1101) ? run + 1 : 0;
      if (run == 3) begin
        found = 1'b1;
        break;
      end
    end
    check("coinc reach digit1 end", 32'(found), 32'd1);
    check("coinc old seg", 32'(seg), 32'(G3));
    bcd = 16'hFEDC; dp = 4'b0100; load = 1'b1;
    step();
    load = 1'b0;
    check("coinc guard idx", 32'(digit_idx), 32'd2);
    check("coinc guard an",  32'(an), 32'hF);
    step();
    check("coinc new an",  32'(an), 32'b1011);
    check("coinc new seg", 32'(seg), 32'(GE));
    check("coinc new dec", 32'(dec), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
